seg_scan_ctrl: RTL and testbench
================================

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter DIV, default 1000: clock cycles each digit is lit; legal range >=2.
REQ-002 SHALL have parameter BLANK, default 2: all-off gap cycles between digits; legal range >=1.
REQ-003 SHALL have port clk, input, 1: the single clock.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port scan_en, input, 1: scanning enable.
REQ-006 SHALL have ports wr_valid/wr_ready, input/output, 1/1: handshake for shadow writes.
REQ-007 SHALL have port wr_idx, input, 3: target digit, 0..7.
REQ-008 SHALL have port wr_val, input, 4: hex value.
REQ-009 SHALL have port wr_blank, input, 1: digit blanked.
REQ-010 SHALL have port wr_dp, input, 1: decimal point on.
REQ-011 SHALL have port commit, input, 1: request to copy shadow to active; accepted when wr_ready=1.
REQ-012 SHALL have port seg_out, output, 8: segment bus, active-low; bit7..bit1 = a..g, bit0 = dp.
REQ-013 SHALL have port an_out, output, 8: digit select, active-low, at most one bit low.

Function
REQ-014 SHALL implement states IDLE, GAP and SHOW, plus a cycle counter cnt and digit index idx (3 bits).
REQ-015 In IDLE, an_out and seg_out SHALL be 8'hFF; scan_en=1 SHALL move to GAP with idx=0, cnt=0.
REQ-016 In GAP, outputs SHALL be 8'hFF; at cnt=BLANK-1 the block SHALL go to SHOW with cnt=0.
REQ-017 In SHOW, an_out SHALL be ~(1<<idx) and seg_out SHALL be decode(active[idx]).
REQ-018 At the end of SHOW (cnt=DIV-1), the block SHALL go to GAP and set idx=idx+1 mod 8 (7 wraps to 0).
REQ-019 Outputs SHALL be combinational decodes of state registers only, with no added latency.
REQ-020 scan_en=0 in any state SHALL enter IDLE next cycle with idx=0 and cnt=0.
REQ-021 A write SHALL occur on wr_valid&wr_ready and SHALL update shadow[wr_idx] next cycle.
REQ-022 An accepted commit SHALL set pending; wr_ready SHALL be 0 while pending=1.
REQ-023 Frame boundary = last SHOW cycle with idx=7; pending SHALL copy shadow to active there, clear, and set wr_ready=1 next cycle.
REQ-024 A commit accepted in IDLE SHALL copy shadow to active on the following cycle.
REQ-025 A write and commit in the same cycle SHALL both be accepted, with the write included in the commit.
REQ-026 Decode SHALL be hex 0-F active-low (0=8'h03, 1=8'h9F, 8=8'h01 with dp off); blank SHALL give 8'hFF, including the dp bit.
REQ-027 The active set SHALL change only at a frame boundary or in IDLE, so no frame mixes old and new values.

Reset
REQ-028 On rst=1 (asynchronous), the block SHALL set state=IDLE, idx=0, cnt=0, pending=0 and wr_ready=1.
REQ-029 On rst=1, all shadow and active entries SHALL become blank=1, val=0, dp=0.
REQ-030 On rst=1, seg_out and an_out SHALL be 8'hFF immediately, including mid-SHOW.

Configuration
REQ-031 With SEG_SCAN_DP_EN defined, dp SHALL be stored per digit and seg_out[0] = ~dp for non-blank digits.
REQ-032 Without SEG_SCAN_DP_EN, wr_dp SHALL be ignored, no dp storage SHALL exist, and seg_out[0] SHALL be 1 always.

Structure
REQ-033 Shared package seg_pkg SHALL hold SEG_BLANK=8'hFF, NUM_DIGITS=8, the state enum, and the digit entry typedef {blank,dp,val}.
REQ-034 The hex-to-segment decoder SHALL be sub-module seg_hex_dec (combinational, 4-bit in, 7-bit a..g out).
REQ-035 cnt width SHALL be $clog2(max(DIV,BLANK)).

Verification (DIV=4, BLANK=1)
REQ-036 Reset: assert rst mid-SHOW -> same cycle seg_out=an_out=8'hFF, wr_ready=1.
REQ-037 Write idx0=0 and idx1=1 (non-blank), commit in IDLE, then scan_en=1 -> seq: 1 cycle FF, then an=FE/seg=03 for 4 cycles, then 1 cycle FF, then an=FD/seg=9F; others FF.
REQ-038 Commit mid-frame at idx=2 -> wr_ready=0 until after idx7 SHOW ends; idx3..7 show old values; new values appear from the next idx0.
REQ-039 wr_valid held while pending -> no accept and shadow unchanged; accepted on the first cycle with wr_ready=1.
REQ-040 scan_en dropped during SHOW idx=5 -> next cycle FF; on re-enable, scanning restarts with GAP then idx0.
REQ-041 Digit0 val=0, dp=1 -> seg_out=8'h02 with SEG_SCAN_DP_EN, 8'h03 without.

Source files
------------

// File: rtl/seg_pkg.sv
// seg_pkg: shared types and constants for the seven-segment scan controller.
// Holds the all-off segment pattern, the digit count, the scan state enum and
// the per-digit entry layout used by seg_scan_ctrl.
package seg_pkg;

  localparam logic [7:0] SEG_BLANK  = 8'hFF;
  localparam int         NUM_DIGITS = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GAP  = 2'd1,
    SHOW = 2'd2
  } state_t;

  typedef struct packed {
    logic       blank;
    logic       dp;
    logic [3:0] val;
  } digit_t;

  // Larger of two integers, used to size the shared cycle counter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/seg_hex_dec.sv
// seg_hex_dec: combinational hex digit to seven-segment decoder.
// Output is active-low, ordered a..g from bit 6 down to bit 0.
module seg_hex_dec (
  input  logic [3:0] val,
  output logic [6:0] seg
);

  // Look up the active-low a..g pattern for each hex value.
  always_comb begin
    seg = 7'h7F;
    case (val)
      4'h0: seg = 7'b000_0001;
      4'h1: seg = 7'b100_1111;
      4'h2: seg = 7'b001_0010;
      4'h3: seg = 7'b000_0110;
      4'h4: seg = 7'b100_1100;
      4'h5: seg = 7'b010_0100;
      4'h6: seg = 7'b010_0000;
      4'h7: seg = 7'b000_1111;
      4'h8: seg = 7'b000_0000;
      4'h9: seg = 7'b000_0100;
      4'hA: seg = 7'b000_1000;
      4'hB: seg = 7'b110_0000;
      4'hC: seg = 7'b011_0001;
      4'hD: seg = 7'b100_0010;
      4'hE: seg = 7'b011_0000;
      4'hF: seg = 7'b011_1000;
      default: seg = 7'h7F;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed 8-digit seven-segment display scanner.
// Each digit is lit for DIV cycles, separated by BLANK all-off cycles.
// Digit values are written into a shadow set and copied into the displayed
// (active) set only at a frame boundary or while idle, so a frame never mixes
// old and new values.
// Optional feature: define SEG_SCAN_DP_EN to store and drive per-digit
// decimal points; otherwise wr_dp is ignored and the dp segment stays off.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int DIV   = 1000,
  parameter int BLANK = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scan_en,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [2:0] wr_idx,
  input  logic [3:0] wr_val,
  input  logic       wr_blank,
  input  logic       wr_dp,
  input  logic       commit,
  output logic [7:0] seg_out,
  output logic [7:0] an_out
);

  localparam int            CW         = $clog2(max_int(DIV, BLANK));
  localparam logic [CW-1:0] DIV_LAST   = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic          pending;

  logic          wr_fire;
  logic          commit_fire;
  logic          frame_end;
  logic          copy_now;

  digit_t        cur;
  logic [6:0]    hex_seg;

`ifdef SEG_SCAN_DP_EN
  digit_t shadow [NUM_DIGITS];
  digit_t active [NUM_DIGITS];
`else
  typedef struct packed {
    logic       blank;
    logic [3:0] val;
  } digit_nodp_t;

  digit_nodp_t shadow [NUM_DIGITS];
  digit_nodp_t active [NUM_DIGITS];

  logic unused_wr_dp;
  assign unused_wr_dp = wr_dp;
`endif

  // The write port is held off for the whole time a commit is outstanding.
  assign wr_ready    = ~pending;
  assign wr_fire     = wr_valid & wr_ready;
  assign commit_fire = commit & wr_ready;

  // Last lit cycle of digit 7 closes the frame.
  assign frame_end = (state == SHOW) && (cnt == DIV_LAST) && (idx == 3'd7);
  assign copy_now  = pending && ((state == IDLE) || frame_end);

  // Scan sequencer: IDLE -> GAP -> SHOW -> GAP ... stepping idx after each SHOW.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
    end else if (!scan_en) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          state <= GAP;
          cnt   <= '0;
          idx   <= '0;
        end
        GAP: begin
          if (cnt == BLANK_LAST) begin
            state <= SHOW;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SHOW: begin
          if (cnt == DIV_LAST) begin
            state <= GAP;
            cnt   <= '0;
            idx   <= idx + 3'd1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          idx   <= '0;
        end
      endcase
    end
  end

  // Commit tracking: set on an accepted commit, cleared once the copy happens.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= 1'b0;
    end else if (copy_now) begin
      pending <= 1'b0;
    end else if (commit_fire) begin
      pending <= 1'b1;
    end
  end

  // Shadow takes accepted writes; active is refreshed from shadow on a copy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
`ifdef SEG_SCAN_DP_EN
        shadow[i] <= '{blank: 1'b1, dp: 1'b0, val: 4'h0};
        active[i] <= '{blank: 1'b1, dp: 1'b0, val: 4'h0};
`else
        shadow[i] <= '{blank: 1'b1, val: 4'h0};
        active[i] <= '{blank: 1'b1, val: 4'h0};
`endif
      end
    end else begin
      if (wr_fire) begin
`ifdef SEG_SCAN_DP_EN
        shadow[wr_idx] <= '{blank: wr_blank, dp: wr_dp, val: wr_val};
`else
        shadow[wr_idx] <= '{blank: wr_blank, val: wr_val};
`endif
      end
      if (copy_now) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          active[i] <= shadow[i];
        end
      end
    end
  end

  // Select the displayed digit entry; dp reads as off when it is not stored.
  always_comb begin
    cur.blank = active[idx].blank;
    cur.val   = active[idx].val;
`ifdef SEG_SCAN_DP_EN
    cur.dp    = active[idx].dp;
`else
    cur.dp    = 1'b0;
`endif
  end

  seg_hex_dec u_hex_dec (
    .val (cur.val),
    .seg (hex_seg)
  );

  // Drive anode and segment buses straight from the registered scan state.
  always_comb begin
    an_out  = SEG_BLANK;
    seg_out = SEG_BLANK;
    if (state == SHOW) begin
      an_out = ~(8'h01 << idx);
      if (!cur.blank) begin
        seg_out = {hex_seg, ~cur.dp};
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: self-checking bench for seg_scan_ctrl with DIV=4, BLANK=1.
// Directed sequences plus randomized traffic, checked every cycle against a
// timeline-based reference model of the display.
module tb_seg_scan_ctrl;

  localparam int DIV   = 4;
  localparam int BLANK = 1;
  localparam int SLOT  = DIV + BLANK;
  localparam int FRAME = 8 * SLOT;

`ifdef SEG_SCAN_DP_EN
  localparam logic [7:0] DP0_SEG = 8'h02;
  localparam bit         DP_ON   = 1'b1;
`else
  localparam logic [7:0] DP0_SEG = 8'h03;
  localparam bit         DP_ON   = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       scan_en, wr_valid, wr_ready, wr_blank, wr_dp, commit;
  logic [2:0] wr_idx;
  logic [3:0] wr_val;
  logic [7:0] seg_out, an_out;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.DIV(DIV), .BLANK(BLANK)) dut (
    .clk      (clk),
    .rst      (rst),
    .scan_en  (scan_en),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_idx   (wr_idx),
    .wr_val   (wr_val),
    .wr_blank (wr_blank),
    .wr_dp    (wr_dp),
    .commit   (commit),
    .seg_out  (seg_out),
    .an_out   (an_out)
  );

  // Reference model: t_m counts cycles since scanning started (-1 = idle).
  logic [7:0] hex_tab [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                               8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};
  int         t_m = -1;
  logic       pend_m = 1'b0;
  logic       sh_b [8], sh_d [8], act_b [8], act_d [8];
  logic [3:0] sh_v [8], act_v [8];

  typedef struct {
    bit         sen;
    logic [7:0] an;
    logic [7:0] seg;
  } vec_t;
  vec_t tbl [11];

  task automatic modelReset();
    t_m    = -1;
    pend_m = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sh_b[i] = 1'b1; sh_d[i] = 1'b0; sh_v[i] = 4'h0;
      act_b[i] = 1'b1; act_d[i] = 1'b0; act_v[i] = 4'h0;
    end
  endtask

  task automatic modelStep();
    bit boundary, do_copy, acc_w, acc_c;
    if (rst) begin
      modelReset();
      return;
    end
    boundary = (t_m >= 0) && ((t_m % FRAME) == FRAME - 1);
    do_copy  = pend_m && ((t_m < 0) || boundary);
    acc_w    = wr_valid && !pend_m;
    acc_c    = commit && !pend_m;
    if (do_copy) begin
      for (int i = 0; i < 8; i++) begin
        act_b[i] = sh_b[i]; act_d[i] = sh_d[i]; act_v[i] = sh_v[i];
      end
      pend_m = 1'b0;
    end
    if (acc_w) begin
      sh_b[wr_idx] = wr_blank; sh_d[wr_idx] = wr_dp; sh_v[wr_idx] = wr_val;
    end
    if (acc_c) pend_m = 1'b1;
    t_m = scan_en ? t_m + 1 : -1;
  endtask

  function automatic logic [7:0] expAn();
    logic [7:0] one = 8'h01;
    int d;
    if (t_m < 0 || (t_m % SLOT) < BLANK) return 8'hFF;
    d = (t_m / SLOT) % 8;
    return ~(one << d);
  endfunction

  function automatic logic [7:0] expSeg();
    logic [7:0] s;
    int d;
    if (t_m < 0 || (t_m % SLOT) < BLANK) return 8'hFF;
    d = (t_m / SLOT) % 8;
    if (act_b[d]) return 8'hFF;
    s = hex_tab[act_v[d]];
    if (DP_ON && act_d[d]) s[0] = 1'b0;
    return s;
  endfunction

  task automatic applyStimulus(input bit sen, input bit wv, input logic [2:0] widx,
                               input logic [3:0] wval, input bit wbl, input bit wdp,
                               input bit cmt);
    scan_en = sen; wr_valid = wv; wr_idx = widx; wr_val = wval;
    wr_blank = wbl; wr_dp = wdp; commit = cmt;
  endtask

  task automatic checkOutput(input string name);
    logic [7:0] ea, es;
    logic       er;
    ea = expAn(); es = expSeg(); er = ~pend_m;
    vectors++;
    if (an_out !== ea || seg_out !== es || wr_ready !== er) begin
      miscompares++;
      $display("[TB] FAIL %s: got an=%h seg=%h rdy=%b, expected an=%h seg=%h rdy=%b",
               name, an_out, seg_out, wr_ready, ea, es, er);
    end
  endtask

  task automatic checkVal(input string name, input logic [7:0] act, input logic [7:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic step();
    modelStep();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle(input string name);
    @(negedge clk);
    checkOutput(name);
    step();
  endtask

  task automatic checkCycle(input string name, input logic [7:0] ea, input logic [7:0] es);
    @(negedge clk);
    checkVal({name, "_an"}, an_out, ea);
    checkVal({name, "_seg"}, seg_out, es);
    checkOutput(name);
    step();
  endtask

  // Leaves the caller at the negedge of the first cycle where an_out == target.
  task automatic waitAn(input logic [7:0] target, input string name);
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      checkOutput(name);
      if (an_out === target) return;
      step();
    end
    miscompares++;
    $display("[TB] FAIL %s: timeout waiting for an=%h, last an=%h", name, target, an_out);
    @(negedge clk);
  endtask

  initial begin
    #300000;
    miscompares++;
    $display("[TB] FAIL watchdog: simulation did not finish, got running, expected done");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit accepted;

    tbl[0]  = '{1'b1, 8'hFF, 8'hFF};
    tbl[1]  = '{1'b1, 8'hFE, 8'h03};
    tbl[2]  = '{1'b1, 8'hFE, 8'h03};
    tbl[3]  = '{1'b1, 8'hFE, 8'h03};
    tbl[4]  = '{1'b1, 8'hFE, 8'h03};
    tbl[5]  = '{1'b1, 8'hFF, 8'hFF};
    tbl[6]  = '{1'b1, 8'hFD, 8'h9F};
    tbl[7]  = '{1'b1, 8'hFD, 8'h9F};
    tbl[8]  = '{1'b1, 8'hFD, 8'h9F};
    tbl[9]  = '{1'b1, 8'hFD, 8'h9F};
    tbl[10] = '{1'b1, 8'hFF, 8'hFF};

    // Power-on reset
    applyStimulus(0, 0, 3'd0, 4'h0, 1, 0, 0);
    #1 rst = 1'b1;
    modelReset();
    #10;
    checkVal("por_an", an_out, 8'hFF);
    checkVal("por_seg", seg_out, 8'hFF);
    checkVal("por_rdy", {7'b0, wr_ready}, 8'h01);
    @(negedge clk);
    rst = 1'b0;
    step();

    // Load digits 0 and 1, commit while idle, then start scanning
    applyStimulus(0, 1, 3'd0, 4'h0, 0, 0, 0); cycle("wr_d0");
    applyStimulus(0, 1, 3'd1, 4'h1, 0, 0, 0); cycle("wr_d1");
    applyStimulus(0, 0, 3'd0, 4'h0, 1, 0, 1); cycle("commit_idle");
    applyStimulus(0, 0, 3'd0, 4'h0, 1, 0, 0); cycle("copy_idle");
    applyStimulus(1, 0, 3'd0, 4'h0, 1, 0, 0); cycle("enable");
    for (int i = 0; i < 11; i++) begin
      applyStimulus(tbl[i].sen, 0, 3'd0, 4'h0, 1, 0, 0);
      checkCycle($sformatf("seq%0d", i), tbl[i].an, tbl[i].seg);
    end

    // Commit mid-frame at digit 2: rest of this frame keeps old values
    applyStimulus(1, 1, 3'd0, 4'h8, 0, 0, 0); cycle("wr_new0");
    applyStimulus(1, 1, 3'd3, 4'h3, 0, 0, 0); cycle("wr_new3");
    applyStimulus(1, 0, 3'd0, 4'h0, 1, 0, 0);
    waitAn(8'hFB, "find_d2");
    commit = 1'b1;
    step();
    commit = 1'b0;
    waitAn(8'hF7, "find_d3");
    checkVal("d3_old_seg", seg_out, 8'hFF);
    checkVal("d3_rdy_low", {7'b0, wr_ready}, 8'h00);
    step();
    waitAn(8'h7F, "find_d7");
    checkVal("d7_rdy_low", {7'b0, wr_ready}, 8'h00);
    step();
    waitAn(8'hFE, "find_new_d0");
    checkVal("d0_new_seg", seg_out, 8'h01);
    checkVal("d0_rdy_high", {7'b0, wr_ready}, 8'h01);

    // Write held during pending is stalled, then accepted alongside a commit
    commit = 1'b1;
    step();
    applyStimulus(1, 1, 3'd4, 4'h5, 0, 0, 0);
    accepted = 1'b0;
    for (int n = 0; n < 100 && !accepted; n++) begin
      @(negedge clk);
      checkOutput("held_wr");
      if (wr_ready === 1'b1) begin
        commit   = 1'b1;
        accepted = 1'b1;
      end
      step();
    end
    checkVal("held_accepted", {7'b0, accepted}, 8'h01);
    applyStimulus(1, 0, 3'd0, 4'h0, 1, 0, 0);
    waitAn(8'hEF, "find_d4_old");
    checkVal("d4_old_seg", seg_out, 8'hFF);
    step();
    waitAn(8'h7F, "find_d7b");
    step();
    waitAn(8'hEF, "find_d4_new");
    checkVal("d4_new_seg", seg_out, 8'h49);
    step();

    // Drop scan_en while showing digit 5, then re-enable
    waitAn(8'hDF, "find_d5");
    scan_en = 1'b0;
    step();
    checkCycle("drop", 8'hFF, 8'hFF);
    scan_en = 1'b1;
    checkCycle("reen_idle", 8'hFF, 8'hFF);
    checkCycle("reen_gap", 8'hFF, 8'hFF);
    checkCycle("reen_d0", 8'hFE, 8'h01);

    // Decimal point on digit 0
    applyStimulus(0, 0, 3'd0, 4'h0, 1, 0, 0); cycle("stop");
    applyStimulus(0, 1, 3'd0, 4'h0, 0, 1, 1); cycle("wr_dp_commit");
    applyStimulus(0, 0, 3'd0, 4'h0, 1, 0, 0); cycle("copy_dp");
    applyStimulus(1, 0, 3'd0, 4'h0, 1, 0, 0);
    waitAn(8'hFE, "find_dp_d0");
    checkVal("dp_seg", seg_out, DP0_SEG);

    // Asynchronous reset mid-SHOW with a commit outstanding
    commit = 1'b1;
    step();
    commit = 1'b0;
    rst = 1'b1;
    modelReset();
    #1;
    checkVal("rst_an", an_out, 8'hFF);
    checkVal("rst_seg", seg_out, 8'hFF);
    checkVal("rst_rdy", {7'b0, wr_ready}, 8'h01);
    @(negedge clk);
    checkOutput("rst_hold");
    rst = 1'b0;
    step();
    waitAn(8'hFE, "post_rst_d0");
    checkVal("post_rst_blank", seg_out, 8'hFF);
    step();

    // Randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      applyStimulus($urandom_range(0, 59) != 0, $urandom_range(0, 2) == 0,
                    3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                    $urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 15) == 0);
      cycle("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
